// File: rtl/micro8085_bus_pkg.sv
// Shared definitions for the 8085-style external bus cycle unit.
// Holds the T-state encoding, the S1/S0 status codes and the data value
// returned when a cycle is aborted on wait timeout. No ports.
package micro8085_bus_pkg;

  // Bus T-states. TW is the wait state inserted between T2 and T3.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } t_state_e;

  // S1/S0 status codes.
  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_WRITE = 2'b01;
  localparam logic [1:0] S_READ  = 2'b10;
  localparam logic [1:0] S_FETCH = 2'b11;

  // Read data handed back when a cycle times out waiting for READY.
  localparam logic [7:0] ABORT_DATA = 8'hFF;

  // Status code for a transfer type; fetch wins over the write flag.
  function automatic logic [1:0] status_code(input logic write, input logic fetch);
    status_code = fetch ? S_FETCH : (write ? S_WRITE : S_READ);
  endfunction

endpackage

// File: rtl/bus_cycle_unit_if.sv
// Request/response channel between the control unit and the bus cycle unit.
// Request side: req_valid/req_ready handshake, transfer type, address, write data, halt_req.
// Response side: rdata with a one-cycle done pulse and a coincident bus_err on abort.
interface bus_cycle_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic        req_fetch;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        halt_req;
  logic [7:0]  rdata;
  logic        done;
  logic        bus_err;

  // Control unit side.
  modport master (
    output req_valid, req_write, req_io, req_fetch, req_addr, req_wdata, halt_req,
    input  req_ready, rdata, done, bus_err
  );

  // Bus cycle unit side.
  modport slave (
    input  req_valid, req_write, req_io, req_fetch, req_addr, req_wdata, halt_req,
    output req_ready, rdata, done, bus_err
  );
endinterface

// File: rtl/bus_wait_counter.sv
// Counts consecutive TW states of the current bus cycle.
// Ports: clk, rst_n, clr (synchronous clear), inc (count one TW),
// term (high when the increment in progress lands on MAX_WAIT).
module bus_wait_counter #(
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Looks one count ahead so the FSM can leave TW on the same edge the
  // counter reaches MAX_WAIT, giving exactly MAX_WAIT wait states.
  assign term = (cnt == WAIT_CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/bus_cycle_unit.sv
// Turns single-level memory/IO requests into 8085 multiplexed bus cycles
// (T1, T2, TW*, T3, T4 on fetch) and returns read data with a done pulse.
// Ports: clk, rst_n, req (request/response interface), bus_ready, ad_in,
// and the registered bus pins ad_out/ad_oe/a_hi/ale/rd_n/wr_n/io_m/s1/s0/halted.
module bus_cycle_unit
  import micro8085_bus_pkg::*;
#(
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bus_cycle_unit_if.slave         req,
  input  logic                    bus_ready,
  input  logic [7:0]              ad_in,
  output logic [7:0]              ad_out,
  output logic                    ad_oe,
  output logic [7:0]              a_hi,
  output logic                    ale,
  output logic                    rd_n,
  output logic                    wr_n,
  output logic                    io_m,
  output logic                    s1,
  output logic                    s0,
  output logic                    halted
);

  t_state_e    state_q, state_d;

  // Transfer latched at accept; request inputs are ignored afterwards.
  logic [7:0]  wdata_q;
  logic        write_q, io_q, fetch_q, abort_q;

  logic        accept, bad_req, set_abort, finish;
  logic        cnt_clr, cnt_inc, cnt_term;

  logic        ale_d, rd_n_d, wr_n_d, ad_oe_d, io_m_d, halted_d, rdy_d;
  logic [7:0]  ad_out_d, a_hi_d, rdata_d;
  logic [1:0]  s_d;
  logic        rdy_q, done_q, err_q;
  logic [7:0]  rdata_q;

  bus_wait_counter #(
    .MAX_WAIT   (MAX_WAIT),
    .WAIT_CNT_W (WAIT_CNT_W)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    bad_req   = 1'b0;
    set_abort = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.halt_req) begin
          state_d = ST_HALT;
        end else if (req.req_valid) begin
          accept = 1'b1;
          // A write-fetch is meaningless: reject it without touching the bus.
          if (req.req_write && req.req_fetch) bad_req = 1'b1;
          else                                state_d = ST_T1;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        if (bus_ready) begin
          state_d = ST_T3;
        end else begin
          state_d = ST_TW;
          cnt_clr = 1'b1;
        end
      end
      ST_TW: begin
        if (bus_ready) begin
          state_d = ST_T3;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_term) begin
            state_d   = ST_T3;
            set_abort = 1'b1;
          end
        end
      end
      ST_T3:   state_d = fetch_q ? ST_T4 : ST_IDLE;
      ST_T4:   state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaving the last T-state of a cycle; done is registered from this.
  assign finish = ((state_q == ST_T3) && !fetch_q) || (state_q == ST_T4);

  // Output values for the state being entered, registered below.
  always_comb begin
    ale_d    = 1'b0;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out;
    a_hi_d   = a_hi;
    io_m_d   = io_m;
    s_d      = {s1, s0};
    halted_d = 1'b0;
    rdy_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_d)
      ST_IDLE: rdy_d = 1'b1;
      // T1 is only entered from an accept, so the live request fields are
      // the ones being latched on this same edge.
      ST_T1: begin
        ale_d    = 1'b1;
        a_hi_d   = req.req_addr[15:8];
        ad_out_d = req.req_addr[7:0];
        ad_oe_d  = 1'b1;
        io_m_d   = req.req_io;
        s_d      = status_code(req.req_write, req.req_fetch);
      end
      ST_T2, ST_TW, ST_T3: begin
        if (write_q) begin
          ad_out_d = wdata_q;
          ad_oe_d  = 1'b1;
          wr_n_d   = 1'b0;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
        s_d      = S_HALT;
      end
      default: ;
    endcase
    if (state_q == ST_T3) begin
      if (abort_q)       rdata_d = ABORT_DATA;
      else if (!write_q) rdata_d = ad_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
      write_q <= 1'b0;
      io_q    <= 1'b0;
      fetch_q <= 1'b0;
      abort_q <= 1'b0;
      ale     <= 1'b0;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
      a_hi    <= '0;
      io_m    <= 1'b0;
      s1      <= 1'b0;
      s0      <= 1'b0;
      halted  <= 1'b0;
      rdy_q   <= 1'b1;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wdata_q <= req.req_wdata;
        write_q <= req.req_write;
        io_q    <= req.req_io;
        fetch_q <= req.req_fetch;
        abort_q <= 1'b0;
      end else if (set_abort) begin
        abort_q <= 1'b1;
      end
      ale     <= ale_d;
      rd_n    <= rd_n_d;
      wr_n    <= wr_n_d;
      ad_oe   <= ad_oe_d;
      ad_out  <= ad_out_d;
      a_hi    <= a_hi_d;
      io_m    <= io_m_d;
      s1      <= s_d[1];
      s0      <= s_d[0];
      halted  <= halted_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      done_q  <= bad_req | finish;
      err_q   <= bad_req | (finish & abort_q);
    end
  end

  assign req.req_ready = rdy_q;
  assign req.rdata     = rdata_q;
  assign req.done      = done_q;
  assign req.bus_err   = err_q;

endmodule
